// File: rtl/uart_rx_frame_if.sv
// Bus between the serial-line side and the parallel-byte side of uart_rx_frame.
// The slave modport is the receiver itself; the master modport is whoever
// drives the line and the frame configuration and consumes the received bytes.
interface uart_rx_frame_if #(
  parameter int Data_width     = 8,
  parameter int Prescale_width = 6
);
  logic                      RX_IN;
  logic [Prescale_width-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [Data_width-1:0]     P_DATA;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, parity_error, framing_error
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver. Each bit is sampled three times around its
// middle and resolved by 2-of-3 majority; all decisions happen on the last
// oversampling tick of a bit so results land exactly N*P cycles after the
// start edge. Optional even/odd parity, parity and framing error strobes.
module uart_rx_frame #(
  parameter int Data_width     = 8,
  parameter int Prescale_width = 6
) (
  input logic             CLK,
  input logic             RST,
  uart_rx_frame_if.slave  bus
);

  localparam int BCW = (Data_width > 1) ? $clog2(Data_width) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [Prescale_width-1:0] p_r;
  logic [Prescale_width-1:0] p_sel_s;
  logic [Prescale_width-1:0] half_s;
  logic [Prescale_width-1:0] edge_r;
  logic [Prescale_width-1:0] edge_nxt_s;
  logic [BCW-1:0]            bit_r;
  logic                      par_en_r;
  logic                      par_typ_r;
  logic [2:0]                smp_r;
  logic [Data_width-1:0]     shift_r;
  logic [Data_width-1:0]     pdata_r;
  logic                      par_err_r;
  logic                      dv_r;
  logic                      pe_r;
  logic                      fe_r;
  logic                      start_s;
  logic                      last_edge_s;
  logic                      last_bit_s;
  logic                      bit_val_s;

  // 2-of-3 majority vote of the three mid-bit samples.
  function automatic logic maj3_f(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Expected parity bit: XOR of the data, inverted for odd parity.
  function automatic logic par_exp_f(input logic [Data_width-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // Map the requested prescale onto the supported set; anything else means 8.
  always_comb begin
    p_sel_s = Prescale_width'(8);
    case (bus.Prescale)
      Prescale_width'(8):  p_sel_s = Prescale_width'(8);
      Prescale_width'(16): p_sel_s = Prescale_width'(16);
      Prescale_width'(32): p_sel_s = Prescale_width'(32);
      default:             p_sel_s = Prescale_width'(8);
    endcase
  end

  assign start_s     = (state_r == IDLE) && !bus.RX_IN;
  assign half_s      = p_r >> 1;
  assign last_edge_s = (edge_r == (p_r - Prescale_width'(1)));
  assign last_bit_s  = (bit_r == BCW'(Data_width - 1));
  assign bit_val_s   = maj3_f(smp_r);

  // Next-state logic and edge-counter advance; the start cycle itself is edge 0.
  always_comb begin
    state_nxt_s = state_r;
    edge_nxt_s  = edge_r;
    case (state_r)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (last_edge_s) begin
          if (bit_val_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (last_edge_s && last_bit_s) begin
          if (par_en_r) begin
            state_nxt_s = PARITY;
          end else begin
            state_nxt_s = STOP;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (last_edge_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (last_edge_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    if (state_r == IDLE) begin
      if (!bus.RX_IN) begin
        edge_nxt_s = Prescale_width'(1);
      end else begin
        edge_nxt_s = Prescale_width'(0);
      end
    end else if (last_edge_s) begin
      edge_nxt_s = Prescale_width'(0);
    end else begin
      edge_nxt_s = edge_r + Prescale_width'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: config latch, sampling, shifting, parity check and output strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_r       <= Prescale_width'(0);
      edge_r    <= Prescale_width'(0);
      bit_r     <= BCW'(0);
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      smp_r     <= 3'b000;
      shift_r   <= Data_width'(0);
      pdata_r   <= Data_width'(0);
      par_err_r <= 1'b0;
      dv_r      <= 1'b0;
      pe_r      <= 1'b0;
      fe_r      <= 1'b0;
    end else begin
      dv_r   <= 1'b0;
      pe_r   <= 1'b0;
      fe_r   <= 1'b0;
      edge_r <= edge_nxt_s;
      if (start_s) begin
        p_r       <= p_sel_s;
        par_en_r  <= bus.PAR_EN;
        par_typ_r <= bus.PAR_TYP;
        par_err_r <= 1'b0;
        bit_r     <= BCW'(0);
        shift_r   <= Data_width'(0);
      end else if (state_r != IDLE) begin
        if (edge_r == (half_s - Prescale_width'(1))) begin
          smp_r[0] <= bus.RX_IN;
        end
        if (edge_r == half_s) begin
          smp_r[1] <= bus.RX_IN;
        end
        if (edge_r == (half_s + Prescale_width'(1))) begin
          smp_r[2] <= bus.RX_IN;
        end
        if (last_edge_s) begin
          case (state_r)
            DATA: begin
              shift_r <= {bit_val_s, shift_r[Data_width-1:1]};
              bit_r   <= last_bit_s ? BCW'(0) : (bit_r + BCW'(1));
            end
            PARITY: begin
              if (bit_val_s != par_exp_f(shift_r, par_typ_r)) begin
                par_err_r <= 1'b1;
              end
            end
            STOP: begin
              if (bit_val_s && !par_err_r) begin
                pdata_r <= shift_r;
                dv_r    <= 1'b1;
              end
              fe_r <= !bit_val_s;
              pe_r <= par_err_r;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.P_DATA        = pdata_r;
  assign bus.data_valid    = dv_r;
  assign bus.parity_error  = pe_r;
  assign bus.framing_error = fe_r;

endmodule
